mc_control_unit: RTL
====================

Name: mc_control_unit

Overview:
- Multi-cycle MIPS control unit. It sits on the opposite side of the control interface from `datapath`: it drives `regDst`, `regWrite`, `ALUSrc`, `ALUcontrol`, `memWrite`, `memRead` and `memtoReg` itself instead of a bench forcing them.
- Input is the opcode/funct of the latched instruction plus `isZero` from the ALU.
- A Moore FSM sequences fetch, decode, execute, memory and writeback. A programmable wait counter stretches memory accesses.

Parameters:
- MEM_LAT, 0: extra wait cycles spent in each memory state (`MEM_READ` and `MEM_WRITE`) before it completes; range 0..15.
- ALU_W, 4: width of `ALUcontrol`.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- OPCODE  input  6  `INST[31:26]` of the instruction register
- FUNCT  input  6  `INST[5:0]` of the instruction register
- isZero  input  1  ALU zero flag (combinational from the datapath)
- PCWrite  output  1  load PC this cycle
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut
- IRWrite  output  1  load instruction register
- regDst  output  1  destination register: 1 = rd, 0 = rt
- regWrite  output  1  register-file write enable
- ALUSrcA  output  1  ALU A operand: 0 = PC, 1 = rs
- ALUSrc  output  2  ALU B operand: 00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- ALUcontrol  output  ALU_W  ALU operation: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- PCSource  output  2  next-PC source: 00 ALU result, 01 ALUOut, 10 jump target
- memWrite  output  1  data-memory write
- memRead  output  1  data-memory read
- memtoReg  output  1  write-back data: 1 = MDR, 0 = ALUOut
- illegal  output  1  one-cycle pulse on an unsupported opcode or funct

Behaviour:
- States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- Reset: state = FETCH, wait counter = 0. All outputs are 0 while `RST` is high. Reset asserted mid-instruction aborts it immediately; no partial `regWrite` or `memWrite` may follow.
- Outputs are decoded from the state register only. Sole exception: `PCWrite` in BRANCH equals `isZero`.
- FETCH:
  - Outputs: `memRead`=1, `IorD`=0, `IRWrite`=1, `ALUSrcA`=0, `ALUSrc`=01, `ALUcontrol`=0010, `PCSource`=00, `PCWrite`=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: `ALUSrcA`=0, `ALUSrc`=11, `ALUcontrol`=0010 (branch target into ALUOut).
  - Dispatch on `OPCODE`:
    - 000000 → EXEC_R
    - 100011 (lw) or 101011 (sw) → MEM_ADDR
    - 001000 (addi) → EXEC_I
    - 000100 (beq) → BRANCH
    - 000010 (j) → JUMP
    - anything else → FETCH, with `illegal`=1 for this cycle.
- MEM_ADDR:
  - Outputs: `ALUSrcA`=1, `ALUSrc`=10, `ALUcontrol`=0010.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ and MEM_WRITE:
  - MEM_READ asserts `memRead`=1, `IorD`=1; MEM_WRITE asserts `memWrite`=1, `IorD`=1.
  - The state is held for MEM_LAT+1 cycles. The counter is loaded with MEM_LAT on entry and decrements each cycle; the state exits when the counter is 0.
  - Exit: MEM_READ → MEM_WB, MEM_WRITE → FETCH.
- MEM_WB:
  - Outputs: `regWrite`=1, `regDst`=0, `memtoReg`=1.
  - Next state: FETCH.
- EXEC_R:
  - Outputs: `ALUSrcA`=1, `ALUSrc`=00.
  - `ALUcontrol` from `FUNCT`: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 101010→0111.
  - Next state: R_WB. An unknown funct instead goes to FETCH with `illegal`=1 and no write-back.
- R_WB:
  - Outputs: `regWrite`=1, `regDst`=1, `memtoReg`=0.
  - Next state: FETCH.
- EXEC_I:
  - Outputs: `ALUSrcA`=1, `ALUSrc`=10, `ALUcontrol`=0010.
  - Next state: I_WB.
- I_WB:
  - Outputs: `regWrite`=1, `regDst`=0, `memtoReg`=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: `ALUSrcA`=1, `ALUSrc`=00, `ALUcontrol`=0110, `PCSource`=01, `PCWrite`=`isZero`.
  - Next state: FETCH.
- JUMP:
  - Outputs: `PCSource`=10, `PCWrite`=1.
  - Next state: FETCH.
- Latency in cycles, MEM_LAT=0: R-type 4, addi 4, lw 5, sw 4, beq 3, j 3. Each memory state adds MEM_LAT cycles.
- `regWrite` and `memWrite` are never high in the same cycle. `memWrite` is never high in any state other than MEM_WRITE.
- `OPCODE` and `FUNCT` are sampled only in DECODE and EXEC_R. The instruction register must be stable from DECODE until the instruction completes.

Decomposition:
- Shared package `mips_ctrl_pkg` holds:
  - state encoding constants;
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`, `OP_J`);
  - funct constants;
  - `ALUcontrol` codes;
  - `ALUSrc` and `PCSource` select codes.
- One natural sub-module, `alu_decoder`: combinational mapping from `FUNCT` to `ALUcontrol` plus an illegal flag. It is reused by the single-cycle `datapath` bench.

Test Plan:
- Reset: hold `RST`=1, apply CLK → all outputs 0, state FETCH. Release `RST` → FETCH outputs appear immediately (`IRWrite`=1, `PCWrite`=1, `ALUSrc`=01).
- add $17,$18,$19 (`OPCODE`=000000, `FUNCT`=100000) → `ALUcontrol`=0010 in EXEC_R. The 4th cycle (R_WB) shows `regWrite`=1, `regDst`=1, `memtoReg`=0. The next cycle is FETCH.
- lw with MEM_LAT=2 → `memRead`=1, `IorD`=1 for exactly 3 consecutive cycles. Then MEM_WB shows `regWrite`=1, `memtoReg`=1, `regDst`=0. Total 7 cycles.
- beq twice, `isZero`=1 then `isZero`=0 → BRANCH shows `PCWrite`=1 then 0, with `PCSource`=01 and `ALUcontrol`=0110 both times. 3 cycles each.
- `OPCODE`=111111, and separately R-type with `FUNCT`=000111 → `illegal` pulses high for one cycle, no `regWrite` or `memWrite` occurs, FSM returns to FETCH.
- Assert `RST` during MEM_WRITE with MEM_LAT=3 → `memWrite` drops to 0 asynchronously before the next edge. FSM restarts at FETCH after `RST` is released.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared encodings for the multi-cycle MIPS control unit and the ALU decoder:
// FSM state type, opcode/funct values, ALU operation codes, ALU operand-B and
// next-PC select codes, and the packed control word driven by the FSM.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

  // FSM states
  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    R_WB      = 4'd7,
    EXEC_I    = 4'd8,
    I_WB      = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11
  } state_t;

  // Opcodes (INST[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (INST[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  // ALU operand-B select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Width of the memory wait counter (covers MEM_LAT 0..15)
  localparam int CNT_W = 4;

  // Full control word produced by the FSM each cycle
  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src;
    logic [3:0] alu_control;
    logic [1:0] pc_source;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  // True for the two opcodes that go through address calculation
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational R-type funct -> ALU operation decode.
// Ports:
//   funct       in  6  INST[5:0]
//   alu_control out 4  ALU operation code
//   illegal     out 1  funct is not one of add/sub/and/or/slt
// ---------------------------------------------------------------------------
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (funct)
      FN_ADD:  alu_control = ALU_ADD;
      FN_SUB:  alu_control = ALU_SUB;
      FN_AND:  alu_control = ALU_AND;
      FN_OR:   alu_control = ALU_OR;
      FN_SLT:  alu_control = ALU_SLT;
      default: illegal     = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// ---------------------------------------------------------------------------
// mc_control_unit
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and write-back, with a wait counter that stretches each memory state
// to MEM_LAT+1 cycles.
// Parameters: MEM_LAT (0..15) extra memory wait cycles, ALU_W ALUcontrol width.
// Ports:
//   CLK, RST (async, active-high)
//   OPCODE[5:0], FUNCT[5:0]  fields of the instruction register
//   isZero                   ALU zero flag (only used in BRANCH)
//   PCWrite, IorD, IRWrite, regDst, regWrite, ALUSrcA, ALUSrc[1:0],
//   ALUcontrol[ALU_W-1:0], PCSource[1:0], memWrite, memRead, memtoReg,
//   illegal (one-cycle pulse on unsupported opcode/funct)
// ---------------------------------------------------------------------------
module mc_control_unit
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0,
  parameter int unsigned ALU_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       OPCODE,
  input  logic [5:0]       FUNCT,
  input  logic             isZero,
  output logic             PCWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             regDst,
  output logic             regWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrc,
  output logic [ALU_W-1:0] ALUcontrol,
  output logic [1:0]       PCSource,
  output logic             memWrite,
  output logic             memRead,
  output logic             memtoReg,
  output logic             illegal
);

  localparam logic [CNT_W-1:0] LAT     = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  // lw/sw choice is captured in DECODE so MEM_ADDR need not look at OPCODE
  logic             store_reg, store_next;

  logic [3:0] dec_alu_control;
  logic       dec_illegal;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  alu_decoder u_alu_decoder (
    .funct       (FUNCT),
    .alu_control (dec_alu_control),
    .illegal     (dec_illegal)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
      store_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      store_reg <= store_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    store_next = store_reg;
    ctrl       = '0;

    case (state_reg)
      FETCH: begin
        ctrl.mem_read    = 1'b1;
        ctrl.ir_write    = 1'b1;
        ctrl.alu_src     = SRCB_FOUR;
        ctrl.alu_control = ALU_ADD;
        ctrl.pc_source   = PC_ALU;
        ctrl.pc_write    = 1'b1;
        state_next       = DECODE;
      end

      DECODE: begin
        // Branch target computed speculatively into ALUOut
        ctrl.alu_src     = SRCB_IMM_SH;
        ctrl.alu_control = ALU_ADD;
        store_next       = (OPCODE == OP_SW);
        if (is_mem_op(OPCODE)) begin
          state_next = MEM_ADDR;
        end else begin
          case (OPCODE)
            OP_RTYPE: state_next = EXEC_R;
            OP_ADDI:  state_next = EXEC_I;
            OP_BEQ:   state_next = BRANCH;
            OP_J:     state_next = JUMP;
            default: begin
              state_next   = FETCH;
              ctrl.illegal = 1'b1;
            end
          endcase
        end
      end

      MEM_ADDR: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src     = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        cnt_next         = LAT;
        state_next       = store_reg ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (cnt_reg == '0) state_next = MEM_WB;
        else               cnt_next   = cnt_reg - CNT_ONE;
      end

      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (cnt_reg == '0) state_next = FETCH;
        else               cnt_next   = cnt_reg - CNT_ONE;
      end

      MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        state_next      = FETCH;
      end

      EXEC_R: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src     = SRCB_RT;
        ctrl.alu_control = dec_alu_control;
        if (dec_illegal) begin
          ctrl.illegal = 1'b1;
          state_next   = FETCH;
        end else begin
          state_next   = R_WB;
        end
      end

      R_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        state_next      = FETCH;
      end

      EXEC_I: begin
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src     = SRCB_IMM;
        ctrl.alu_control = ALU_ADD;
        state_next       = I_WB;
      end

      I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        state_next      = FETCH;
      end

      BRANCH: begin
        // The only Mealy-style output: the PC loads only if rs == rt
        ctrl.alu_src_a   = 1'b1;
        ctrl.alu_src     = SRCB_RT;
        ctrl.alu_control = ALU_SUB;
        ctrl.pc_source   = PC_ALUOUT;
        ctrl.pc_write    = isZero;
        state_next       = FETCH;
      end

      JUMP: begin
        ctrl.pc_source = PC_JUMP;
        ctrl.pc_write  = 1'b1;
        state_next     = FETCH;
      end

      default: state_next = FETCH;
    endcase
  end

  // Outputs are forced low combinationally while RST is high so that an
  // in-flight memWrite/regWrite is cut before the next clock edge.
  assign ctrl_out = RST ? '0 : ctrl;

  assign PCWrite    = ctrl_out.pc_write;
  assign IorD       = ctrl_out.iord;
  assign IRWrite    = ctrl_out.ir_write;
  assign regDst     = ctrl_out.reg_dst;
  assign regWrite   = ctrl_out.reg_write;
  assign ALUSrcA    = ctrl_out.alu_src_a;
  assign ALUSrc     = ctrl_out.alu_src;
  assign ALUcontrol = ALU_W'(ctrl_out.alu_control);
  assign PCSource   = ctrl_out.pc_source;
  assign memWrite   = ctrl_out.mem_write;
  assign memRead    = ctrl_out.mem_read;
  assign memtoReg   = ctrl_out.mem_to_reg;
  assign illegal    = ctrl_out.illegal;

endmodule
